id_operand_stage: RTL and testbench

- Decode/operand-fetch stage of the 5-stage pipeline; sits directly downstream of the register file.
- Drives the register file read addresses and consumes its two read-data outputs.
- Resolves RAW hazards by forwarding from EX, MEM and WB, or by a load-use stall.
- Registers the decoded instruction and operands into the ID/EX pipeline register.

---
 rtl/id_operand_stage.sv | 173 +++++++++++++++++
 tb/tb_id_operand_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: decodes IF/ID, forwards operands from EX/MEM/WB,
// detects load-use hazards and registers the result into ID/EX. ID_PERF_CNT_EN adds stall/flush counters.
module id_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rstd,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            flush,
  output logic [RA_W-1:0] rf_addr1,
  output logic [RA_W-1:0] rf_addr2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            ex_we,
  input  logic [RA_W-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_we,
  input  logic [RA_W-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
`ifdef ID_PERF_CNT_EN
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt,
`endif
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [5:0]      id_op,
  output logic [5:0]      id_funct,
  output logic [XLEN-1:0] id_rs_val,
  output logic [XLEN-1:0] id_rt_val,
  output logic [XLEN-1:0] id_imm,
  output logic [RA_W-1:0] id_dest,
  output logic            id_we,
  output logic            id_is_load
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [5:0]      op;
    logic [5:0]      funct;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] dest;
    logic            we;
    logic            is_load;
  } idex_t;

  idex_t           idex_d, idex_q;
  logic [RA_W-1:0] rs_addr, rt_addr, dec_dest;
  logic            dec_uses_rs, dec_uses_rt, dec_is_load;
  logic            ex_fwd_en, hazard;
  logic [XLEN-1:0] rs_fwd, rt_fwd;

  assign rs_addr  = RA_W'(if_instr[25:21]);
  assign rt_addr  = RA_W'(if_instr[20:16]);
  assign rf_addr1 = rs_addr;
  assign rf_addr2 = rt_addr;

  // Stores, branches and jumps keep dest at 0, which also forces we low.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    dec_dest    = '0;
    dec_uses_rs = 1'b1;
    dec_uses_rt = 1'b0;
    dec_is_load = 1'b0;
    case (if_instr[31:26])
      OP_RTYPE: begin
        dec_dest    = RA_W'(if_instr[15:11]);
        dec_uses_rt = 1'b1;
      end
      OP_LW: begin
        dec_dest    = rt_addr;
        dec_is_load = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: dec_uses_rt = 1'b1;
      OP_J:                  dec_uses_rs = 1'b0;
      default:               dec_dest    = rt_addr;
    endcase
  end

  // A load sitting in EX has no data yet; its hazard is covered by the stall instead.
  assign ex_fwd_en = ex_we && !idex_q.is_load;

  function automatic logic [XLEN-1:0] fwd_sel(input logic [RA_W-1:0] addr,
                                              input logic [XLEN-1:0] rf_val);
    if (addr == '0)                          return '0;
    else if (ex_fwd_en && ex_addr == addr)   return ex_data;
    else if (mem_we && mem_addr == addr)     return mem_data;
    else if (wb_we && wb_addr == addr)       return wb_data;
    else                                     return rf_val;
  endfunction

  always_comb begin
    rs_fwd = fwd_sel(rs_addr, rf_data1);
    rt_fwd = fwd_sel(rt_addr, rf_data2);
  end

  assign hazard = idex_q.valid && idex_q.is_load && (idex_q.dest != '0) && if_valid &&
                  ((dec_uses_rs && rs_addr == idex_q.dest) ||
                   (dec_uses_rt && rt_addr == idex_q.dest));
  assign stall  = hazard && !flush;

  always_comb begin
    idex_d = '0;
    if (if_valid && !flush && !stall) begin
      idex_d.valid   = 1'b1;
      idex_d.pc      = if_pc;
      idex_d.op      = if_instr[31:26];
      idex_d.funct   = if_instr[5:0];
      idex_d.rs_val  = rs_fwd;
      idex_d.rt_val  = rt_fwd;
      idex_d.imm     = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
      idex_d.dest    = dec_dest;
      idex_d.we      = (dec_dest != '0);
      idex_d.is_load = dec_is_load;
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
    if (!rstd) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign id_valid   = idex_q.valid;
  assign id_pc      = idex_q.pc;
  assign id_op      = idex_q.op;
  assign id_funct   = idex_q.funct;
  assign id_rs_val  = idex_q.rs_val;
  assign id_rt_val  = idex_q.rt_val;
  assign id_imm     = idex_q.imm;
  assign id_dest    = idex_q.dest;
  assign id_we      = idex_q.we;
  assign id_is_load = idex_q.is_load;

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    flush_cnt_d = flush_cnt_q + {31'd0, flush & if_valid};
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: reference model compared every cycle plus directed literal checks.
// Counter checks are compiled only when ID_PERF_CNT_EN is defined.
module tb_id_operand_stage;

  logic        clk;
  logic        rstd;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        flush;
  logic [4:0]  rf_addr1, rf_addr2;
  logic [31:0] rf_data1, rf_data2;
  logic        ex_we, mem_we, wb_we;
  logic [4:0]  ex_addr, mem_addr, wb_addr;
  logic [31:0] ex_data, mem_data, wb_data;
  logic        stall;
  logic [31:0] stall_cnt, flush_cnt;
  logic        id_valid, id_we, id_is_load;
  logic [31:0] id_pc, id_rs_val, id_rt_val, id_imm;
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_dest;

  id_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rstd(rstd), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .flush(flush), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_we(ex_we), .ex_addr(ex_addr), .ex_data(ex_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall),
`ifdef ID_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .id_valid(id_valid), .id_pc(id_pc), .id_op(id_op), .id_funct(id_funct),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_dest(id_dest), .id_we(id_we), .id_is_load(id_is_load)
  );

`ifndef ID_PERF_CNT_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        we;
    logic        is_load;
  } ref_t;

  ref_t        m;
  logic [31:0] m_stall_cnt, m_flush_cnt;
  bit          m_preload;
  logic [31:0] regs [32];

  function automatic bit ref_uses_rs(input logic [5:0] op);
    return op != 6'h02;
  endfunction

  function automatic bit ref_uses_rt(input logic [5:0] op);
    return op inside {6'h00, 6'h2b, 6'h04, 6'h05};
  endfunction

  function automatic logic [4:0] ref_dest(input logic [31:0] ins);
    case (ins[31:26])
      6'h00:                      return ins[15:11];
      6'h2b, 6'h04, 6'h05, 6'h02: return 5'd0;
      default:                    return ins[20:16];
    endcase
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf_val);
    if (a == 5'd0)                              return 32'd0;
    if (ex_we && ex_addr == a && !m.is_load)    return ex_data;
    if (mem_we && mem_addr == a)                return mem_data;
    if (wb_we && wb_addr == a)                  return wb_data;
    return rf_val;
  endfunction

  function automatic bit ref_stall();
    logic [5:0] op;
    op = if_instr[31:26];
    return m.valid && m.is_load && (m.dest != 5'd0) && if_valid && !flush &&
           ((ref_uses_rs(op) && if_instr[25:21] == m.dest) ||
            (ref_uses_rt(op) && if_instr[20:16] == m.dest));
  endfunction

  function automatic ref_t ref_next();
    ref_t n;
    n         = '0;
    n.valid   = 1'b1;
    n.pc      = if_pc;
    n.op      = if_instr[31:26];
    n.funct   = if_instr[5:0];
    n.rs_val  = ref_operand(if_instr[25:21], rf_data1);
    n.rt_val  = ref_operand(if_instr[20:16], rf_data2);
    n.imm     = {{16{if_instr[15]}}, if_instr[15:0]};
    n.dest    = ref_dest(if_instr);
    n.we      = (n.dest != 5'd0);
    n.is_load = (if_instr[31:26] == 6'h23);
    return n;
  endfunction

  always @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      m           <= '0;
      m_stall_cnt <= '0;
      m_flush_cnt <= '0;
    end else begin
      m_stall_cnt <= (m_preload ? 32'hFFFF_FFFF : m_stall_cnt) + (ref_stall() ? 32'd1 : 32'd0);
      m_flush_cnt <= m_flush_cnt + ((flush && if_valid) ? 32'd1 : 32'd0);
      if (!if_valid || flush || ref_stall()) m <= '0;
      else                                   m <= ref_next();
    end
  end

  // Compare process: inputs change only just after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    check("rf_addr1",   rf_addr1,   if_instr[25:21]);
    check("rf_addr2",   rf_addr2,   if_instr[20:16]);
    check("stall",      stall,      ref_stall());
    check("id_valid",   id_valid,   m.valid);
    check("id_pc",      id_pc,      m.pc);
    check("id_op",      id_op,      m.op);
    check("id_funct",   id_funct,   m.funct);
    check("id_rs_val",  id_rs_val,  m.rs_val);
    check("id_rt_val",  id_rt_val,  m.rt_val);
    check("id_imm",     id_imm,     m.imm);
    check("id_dest",    id_dest,    m.dest);
    check("id_we",      id_we,      m.we);
    check("id_is_load", id_is_load, m.is_load);
`ifdef ID_PERF_CNT_EN
    if (!m_preload) begin
      check("stall_cnt", stall_cnt, m_stall_cnt);
      check("flush_cnt", flush_cnt, m_flush_cnt);
    end
`endif
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_if(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
    rf_data1 = regs[ins[25:21]];
    rf_data2 = regs[ins[20:16]];
  endtask

  task automatic set_fwd(input logic e_we, input logic [4:0] e_a, input logic [31:0] e_d,
                         input logic m_we, input logic [4:0] m_a, input logic [31:0] m_d,
                         input logic w_we, input logic [4:0] w_a, input logic [31:0] w_d);
    ex_we = e_we;  ex_addr = e_a;  ex_data = e_d;
    mem_we = m_we; mem_addr = m_a; mem_data = m_d;
    wb_we = w_we;  wb_addr = w_a;  wb_data = w_d;
  endtask

  // Put "lw rX,0(r1)" into ID/EX, then present ins and check the stall decision.
  task automatic load_then(input logic [4:0] ld_rt, input logic v, input logic [31:0] ins,
                           input logic exp_stall, input string name);
    set_if(1'b1, 32'h400, mk_i(6'h23, ld_rt, 5'd1, 16'h0));
    cyc();
    set_if(v, 32'h404, ins);
    #1;
    check(name, stall, exp_stall);
    cyc();
  endtask

  typedef struct {
    logic [4:0]  ld_rt;
    logic        v;
    logic [31:0] ins;
    logic        exp;
    string       name;
  } lu_vec_t;

  lu_vec_t lu_tab [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    regs[0] = 32'h0;
    regs[5] = 32'h44;
    m_preload = 1'b0;
    rstd = 1'b0;
    flush = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_if(1'b0, 32'h0, 32'h0);

    repeat (2) @(posedge clk);
    #2;
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_stall", stall, 1'b0);
    rstd = 1'b1;

    // Forwarding priority EX > MEM > WB > RF.
    set_fwd(1, 5, 32'h11, 1, 5, 32'h22, 1, 5, 32'h33);
    set_if(1'b1, 32'h100, mk_r(5'd1, 5'd5, 5'd5));
    cyc();
    check("fwd_ex_rs", id_rs_val, 32'h11);
    check("fwd_ex_rt", id_rt_val, 32'h11);
    check("fwd_dest", id_dest, 5'd1);
    check("fwd_pc", id_pc, 32'h100);
    check("fwd_funct", id_funct, 6'h20);
    set_fwd(0, 5, 32'h11, 1, 5, 32'h22, 1, 5, 32'h33);
    cyc();
    check("fwd_mem_rs", id_rs_val, 32'h22);
    set_fwd(0, 5, 32'h11, 0, 5, 32'h22, 1, 5, 32'h33);
    cyc();
    check("fwd_wb_rs", id_rs_val, 32'h33);
    set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    check("fwd_rf_rt", id_rt_val, 32'h44);

    // r0 guard: zero operand even with garbage on every source.
    regs[0] = 32'h1234;
    set_fwd(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 1, 0, 32'hF00D);
    set_if(1'b1, 32'h104, mk_r(5'd2, 5'd0, 5'd0));
    cyc();
    check("r0_rs", id_rs_val, 32'h0);
    check("r0_rt", id_rt_val, 32'h0);
    set_if(1'b1, 32'h108, mk_i(6'h08, 5'd0, 5'd1, 16'd5));
    cyc();
    check("addi_r0_we", id_we, 1'b0);
    check("addi_r0_imm", id_imm, 32'd5);
    check("addi_r0_rs", id_rs_val, 32'h101);
    regs[0] = 32'h0;
    set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_if(1'b1, 32'h10c, mk_i(6'h08, 5'd2, 5'd1, 16'hFFFD));
    cyc();
    check("neg_imm", id_imm, 32'hFFFF_FFFD);
    check("addi_we", id_we, 1'b1);

    // Load-use: one stall cycle, bubble, then MEM forwards the load value.
    set_if(1'b1, 32'h200, mk_i(6'h23, 5'd3, 5'd1, 16'h0));
    cyc();
    check("lw_is_load", id_is_load, 1'b1);
    check("lw_dest", id_dest, 5'd3);
    set_if(1'b1, 32'h204, mk_r(5'd4, 5'd3, 5'd2));
    set_fwd(1, 3, 32'hBAD, 0, 0, 0, 0, 0, 0);
    #1;
    check("lu_stall", stall, 1'b1);
    cyc();
    check("lu_bubble_valid", id_valid, 1'b0);
    check("lu_bubble_load", id_is_load, 1'b0);
    check("lu_stall_once", stall, 1'b0);
    set_fwd(0, 0, 0, 1, 3, 32'hCAFE, 0, 0, 0);
    cyc();
    check("lu_fwd_rs", id_rs_val, 32'hCAFE);
    check("lu_valid", id_valid, 1'b1);
    check("lu_dest", id_dest, 5'd4);
    set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Flush wins over stall.
    set_if(1'b1, 32'h300, mk_i(6'h23, 5'd3, 5'd1, 16'h0));
    cyc();
    set_if(1'b1, 32'h304, mk_r(5'd4, 5'd3, 5'd2));
    flush = 1'b1;
    #1;
    check("flush_stall", stall, 1'b0);
    cyc();
    check("flush_valid", id_valid, 1'b0);
    flush = 1'b0;

    // Which operand uses trigger the hazard.
    lu_tab[0] = '{5'd3, 1'b1, mk_r(5'd4, 5'd2, 5'd3),             1'b1, "lu_rt_use"};
    lu_tab[1] = '{5'd3, 1'b1, mk_i(6'h2b, 5'd3, 5'd1, 16'h4),     1'b1, "lu_sw_rt"};
    lu_tab[2] = '{5'd3, 1'b1, mk_i(6'h04, 5'd3, 5'd1, 16'h8),     1'b1, "lu_beq_rt"};
    lu_tab[3] = '{5'd3, 1'b1, mk_i(6'h23, 5'd6, 5'd3, 16'h0),     1'b1, "lu_lw_rs"};
    lu_tab[4] = '{5'd3, 1'b1, mk_i(6'h08, 5'd3, 5'd7, 16'h1),     1'b0, "lu_itype_rt"};
    lu_tab[5] = '{5'd3, 1'b1, {6'h02, 5'd3, 5'd3, 16'h0},         1'b0, "lu_j"};
    lu_tab[6] = '{5'd3, 1'b0, mk_r(5'd4, 5'd3, 5'd2),             1'b0, "lu_if_invalid"};
    lu_tab[7] = '{5'd0, 1'b1, mk_r(5'd4, 5'd0, 5'd2),             1'b0, "lu_dest_r0"};
    for (int i = 0; i < 8; i++)
      load_then(lu_tab[i].ld_rt, lu_tab[i].v, lu_tab[i].ins, lu_tab[i].exp, lu_tab[i].name);

    // Asynchronous reset with a stall pending.
    set_if(1'b1, 32'h500, mk_i(6'h23, 5'd3, 5'd1, 16'h0));
    cyc();
    set_if(1'b1, 32'h504, mk_r(5'd4, 5'd3, 5'd2));
    #1;
    check("pre_rst_stall", stall, 1'b1);
    rstd = 1'b0;
    #1;
    check("arst_stall", stall, 1'b0);
    check("arst_valid", id_valid, 1'b0);
    check("arst_load", id_is_load, 1'b0);
    check("arst_pc", id_pc, 32'h0);
    cyc();
    rstd = 1'b1;

    // Three load-use hazards and two valid flushes (plus one invalid flush).
    for (int k = 0; k < 3; k++) begin
      set_if(1'b1, 32'h600, mk_i(6'h23, 5'd3, 5'd1, 16'h0));
      cyc();
      set_if(1'b1, 32'h604, mk_r(5'd4, 5'd3, 5'd2));
      cyc();
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      set_if(1'b1, 32'h700, mk_r(5'd4, 5'd1, 5'd2));
      flush = 1'b1;
      cyc();
    end
    set_if(1'b0, 32'h708, mk_r(5'd4, 5'd1, 5'd2));
    cyc();
    flush = 1'b0;
`ifdef ID_PERF_CNT_EN
    check("stall_cnt_3", stall_cnt, 32'd3);
    check("flush_cnt_2", flush_cnt, 32'd2);
    set_if(1'b1, 32'h800, mk_i(6'h23, 5'd3, 5'd1, 16'h0));
    cyc();
    set_if(1'b1, 32'h804, mk_r(5'd4, 5'd3, 5'd2));
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    m_preload = 1'b1;
    #1;
    release dut.stall_cnt_q;
    cyc();
    m_preload = 1'b0;
    check("stall_cnt_wrap", stall_cnt, 32'd0);
`endif

    set_if(1'b0, 32'h0, 32'h0);
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
